proc_execute: RTL and testbench

Execute stage of the unpipelined 16-bit processor. Sits between decode/register-read and the memory stage. Selects the second operand and computes `alu_result`, which the memory stage uses as data address and the writeback stage uses as register data. Single-cycle ALU operations complete combinationally; MUL runs on an iterative 16-cycle shift-add unit and holds the processor with `stall`.

---
 rtl/proc_execute.sv | 137 +++++++++++++
 tb/tb_proc_execute.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_execute.sv
// Execute stage of the 16-bit unpipelined processor: operand select, single-cycle ALU,
// and an optional iterative shift-add multiplier built when PROC_EXECUTE_MUL_EN is defined.
module proc_execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [3:0]  aluOp,
  input  logic        aluSrc,
  input  logic [15:0] read_data1,
  input  logic [15:0] read_data2,
  input  logic [15:0] immediate,
  output logic [15:0] alu_result,
  output logic        zero,
  output logic        stall,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_RSV = 4'hF;

  function automatic logic [15:0] bit_reverse(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

  logic [15:0] op_b_s;
  logic [3:0]  shamt_s;
  logic [16:0] sum_s;
  logic [31:0] rot_l_s;
  logic [31:0] rot_r_s;
  logic [15:0] alu_comb_s;
  logic [1:0]  state_r;
  logic        mul_start_s;
  logic        mul_illegal_s;
  logic [15:0] product_s;

  // Combinational ALU over the selected operands; rotates use a doubled copy of A.
  always_comb begin
    op_b_s     = aluSrc ? immediate : read_data2;
    shamt_s    = op_b_s[3:0];
    sum_s      = {1'b0, read_data1} + {1'b0, op_b_s};
    rot_l_s    = {read_data1, read_data1} << shamt_s;
    rot_r_s    = {read_data1, read_data1} >> shamt_s;
    alu_comb_s = 16'h0000;
    case (aluOp)
      4'h0:    alu_comb_s = sum_s[15:0];
      4'h1:    alu_comb_s = op_b_s - read_data1;
      4'h2:    alu_comb_s = read_data1 ^ op_b_s;
      4'h3:    alu_comb_s = read_data1 & ~op_b_s;
      4'h4:    alu_comb_s = rot_l_s[31:16];
      4'h5:    alu_comb_s = read_data1 << shamt_s;
      4'h6:    alu_comb_s = rot_r_s[15:0];
      4'h7:    alu_comb_s = read_data1 >> shamt_s;
      4'h8:    alu_comb_s = {15'h0000, (read_data1 == op_b_s)};
      4'h9:    alu_comb_s = {15'h0000, ($signed(read_data1) < $signed(op_b_s))};
      4'hA:    alu_comb_s = {15'h0000, ($signed(read_data1) <= $signed(op_b_s))};
      4'hB:    alu_comb_s = {15'h0000, sum_s[16]};
      4'hC:    alu_comb_s = bit_reverse(read_data1);
      4'hD:    alu_comb_s = op_b_s;
      default: alu_comb_s = 16'h0000;
    endcase
  end

`ifdef PROC_EXECUTE_MUL_EN
  logic [3:0]  cnt_r;
  logic [31:0] acc_r;
  logic [15:0] mul_a_r;
  logic [15:0] mul_b_r;

  assign mul_start_s   = (state_r == ST_IDLE) && instr_valid && (aluOp == OP_MUL);
  assign mul_illegal_s = 1'b0;
  assign product_s     = acc_r[15:0];

  // Multiplier FSM: latch operands, then add one shifted partial product per cycle, LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      acc_r   <= 32'h0000_0000;
      mul_a_r <= 16'h0000;
      mul_b_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mul_start_s) begin
            mul_a_r <= read_data1;
            mul_b_r <= op_b_s;
            acc_r   <= 32'h0000_0000;
            cnt_r   <= 4'd0;
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mul_b_r[cnt_r]) begin
            acc_r <= acc_r + ({16'h0000, mul_a_r} << cnt_r);
          end
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_clk_s;

  assign unused_clk_s  = clk;
  assign state_r       = ST_IDLE;
  assign mul_start_s   = 1'b0;
  assign mul_illegal_s = 1'b1;
  assign product_s     = 16'h0000;
`endif

  // Output mux; reset forces the control outputs low while the ALU stays live.
  always_comb begin
    if (state_r == ST_DONE) begin
      alu_result = product_s;
    end else begin
      alu_result = alu_comb_s;
    end
    zero  = (alu_result == 16'h0000);
    stall = !rst && (mul_start_s || (state_r == ST_BUSY));
    err   = !rst && instr_valid &&
            ((aluOp == OP_RSV) || ((aluOp == OP_MUL) && mul_illegal_s));
  end

endmodule

// File: tb/tb_proc_execute.sv
// Randomized scoreboard bench for proc_execute: a driver queues reference results,
// a negedge monitor pops and compares them whenever the stage is not stalling.
module tb_proc_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [3:0]  aluOp;
  logic        aluSrc;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic [15:0] immediate;
  logic [15:0] alu_result;
  logic        zero;
  logic        stall;
  logic        err;

`ifdef PROC_EXECUTE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [15:0] res;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   mon_en       = 1'b0;
  int   stall_run    = 0;

  proc_execute dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .aluOp(aluOp), .aluSrc(aluSrc),
    .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
    .alu_result(alu_result), .zero(zero), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference ALU computed from the operation definitions with plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned s  = b & 16'h000F;
    int unsigned r  = 0;
    case (op)
      4'h0: r = ua + ub;
      4'h1: r = ub - ua;
      4'h2: r = ua ^ ub;
      4'h3: r = ua & ~ub;
      4'h4: r = (ua << s) | (ua >> (16 - s));
      4'h5: r = ua << s;
      4'h6: r = (ua >> s) | (ua << (16 - s));
      4'h7: r = ua >> s;
      4'h8: r = (ua == ub) ? 1 : 0;
      4'h9: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'hA: r = ($signed(a) <= $signed(b)) ? 1 : 0;
      4'hB: r = ((ua + ub) > 32'd65535) ? 1 : 0;
      4'hC: for (int i = 0; i < 16; i++) if (a[i]) r = r | (1 << (15 - i));
      4'hD: r = ub;
      4'hE: r = MUL_EN ? ua * ub : 0;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] rd2,
                       input logic [15:0] imm, input logic src, input bit scramble);
    exp_t e;
    bit   done = 1'b0;
    e.op     = op;
    e.res    = ref_alu(op, a, src ? imm : rd2);
    e.err    = (op == 4'hF) || (op == 4'hE && !MUL_EN);
    e.stalls = (op == 4'hE && MUL_EN) ? 17 : 0;
    exp_q.push_back(e);
    aluOp = op; read_data1 = a; read_data2 = rd2; immediate = imm; aluSrc = src;
    instr_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else begin
        @(posedge clk); #1;
        if (scramble) begin
          read_data1 = 16'($urandom); read_data2 = 16'($urandom); immediate = 16'($urandom);
        end
      end
    end
    check("stall_bound", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: count stall cycles, then score the presented result against the queue head.
  always @(negedge clk) begin
    if (rst) stall_run = 0;
    else if (mon_en && instr_valid) begin
      if (stall) stall_run++;
      else if (exp_q.size() == 0) check("queue_nonempty", exp_q.size(), 1);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("result_op%0h", e.op), alu_result, e.res);
        check($sformatf("zero_op%0h", e.op), zero, (e.res == 16'h0000));
        check($sformatf("err_op%0h", e.op), err, e.err);
        check($sformatf("stall_cycles_op%0h", e.op), stall_run, e.stalls);
        stall_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] edge_v [5];
    logic [15:0] a, b;
    logic [3:0]  op;
    edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF; edge_v[2] = 16'h8000;
    edge_v[3] = 16'h7FFF; edge_v[4] = 16'h0001;

    // Reset: control outputs low, ALU still combinational.
    rst = 1'b1; instr_valid = 1'b1; aluOp = 4'hF; aluSrc = 1'b1;
    read_data1 = 16'h0005; read_data2 = 16'h0000; immediate = 16'h0003;
    #2;
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);
    aluOp = 4'h0; #1;
    check("rst_alu", alu_result, 16'h0008);
    aluOp = 4'hE; #1;
    check("rst_mul_stall", stall, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(4'h0, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b0);
    issue(4'h1, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b0);
    issue(4'hB, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b0);
    issue(4'h4, 16'h8001, 16'h0004, 16'h0000, 1'b0, 1'b0);
    issue(4'h6, 16'h8001, 16'h0004, 16'h0000, 1'b0, 1'b0);
    issue(4'h7, 16'h8001, 16'h0004, 16'h0000, 1'b0, 1'b0);
    issue(4'h9, 16'hFFFE, 16'h0001, 16'h0000, 1'b0, 1'b0);
    issue(4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0);
    issue(4'hE, 16'h0123, 16'h0045, 16'h0000, 1'b0, 1'b0);
    issue(4'h0, 16'h1000, 16'h0234, 16'h0000, 1'b0, 1'b0);
    issue(4'hE, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    issue(4'hE, 16'h0003, 16'h0007, 16'h0000, 1'b0, 1'b0);

    instr_valid = 1'b0; aluOp = 4'hF; #1;
    check("noinstr_err", err, 0);
    check("noinstr_stall", stall, 0);
    @(posedge clk); #1;

`ifdef PROC_EXECUTE_MUL_EN
    // Reset in the middle of a multiply abandons it.
    mon_en = 1'b0;
    instr_valid = 1'b1; aluOp = 4'hE; aluSrc = 1'b0;
    read_data1 = 16'h0123; read_data2 = 16'h0045;
    repeat (6) @(posedge clk);
    #1;
    check("busy_stall", stall, 1);
    rst = 1'b1; #1;
    check("busy_rst_stall", stall, 0);
    aluOp = 4'h2; #1;
    check("busy_rst_alu", alu_result, 16'h0166);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_alu", alu_result, 16'h0166);
    @(posedge clk); #1;
    mon_en = 1'b1;
    issue(4'hE, 16'h0003, 16'h0007, 16'h0000, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        issue(op, a, 16'($urandom), b, 1'b1, (op == 4'hE) && ($urandom_range(0, 1) == 1));
      else
        issue(op, a, b, 16'($urandom), 1'b0, (op == 4'hE) && ($urandom_range(0, 1) == 1));
    end

    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
